can_bit_timing: RTL

- Downstream stage of the CAN time-quantum generator; consumes its single-cycle tq_tick and the bit-timing configuration.
- Tracks position within the nominal bit (SYNC_SEG / TSEG1 / TSEG2) and applies hard sync and SJW-limited resynchronisation on recessive-to-dominant RX edges.
- Emits the sample point, bit boundary and sampled RX bit to the CAN bit-stream / frame logic.

---
 rtl/can_bit_timing.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/can_bit_timing.sv
// CAN nominal bit timing: SYNC/TSEG1/TSEG2 sequencing per time quantum, hard sync and SJW-limited resync.
// Optional CAN_TRIPLE_SAMPLE_EN: majority vote over the last three tq captures at the sample point.
module can_bit_timing #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tq_tick,
    input  logic [3:0] tseg1,
    input  logic [2:0] tseg2,
    input  logic [1:0] sjw,
    input  logic       rx,
    input  logic       hard_sync_en,
    input  logic       resync_en,
    output logic       sample_point,
    output logic       sampled_bit,
    output logic       bit_tick,
    output logic       sync_seg,
    output logic       in_tseg1,
    output logic       in_tseg2,
    output logic [4:0] tq_position
);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TSEG1 = 2'd1,
        ST_TSEG2 = 2'd2
    } state_t;

    state_t state, state_n;
    logic [4:0] cnt, cnt_n;
    logic [2:0] ext, ext_n;
    logic [4:0] l2eff, l2eff_n;
    logic       resync_done, resync_done_n;
    logic [3:0] tseg1_l;
    logic [2:0] tseg2_l;
    logic [1:0] sjw_l;
    logic       latch_cfg;

    logic [SYNC_STAGES-1:0] sync_q;
    logic rx_s, rx_prev, rx_edge, hard, resync, sample_val;
    logic sample_n, bit_tick_n, sampled_n;
    logic [4:0] l1, l2, s_len, l2_short, l1_n, pos_n, min_cs;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign rx_edge  = tq_tick & rx_prev & ~rx_s;
    assign hard     = rx_edge & hard_sync_en;
    assign resync   = rx_edge & resync_en & ~hard_sync_en & ~resync_done;

    assign l1       = 5'(tseg1_l) + 5'd1 + 5'(ext);
    assign l2       = 5'(tseg2_l) + 5'd1;
    assign s_len    = 5'(sjw_l) + 5'd1;
    // Only consulted when the edge is far enough from the bit end, so it never underflows.
    assign l2_short = l2 - s_len;
    assign min_cs   = (cnt < s_len) ? cnt : s_len;

`ifdef CAN_TRIPLE_SAMPLE_EN
    // Two previous tq captures; the current capture is rx_s itself.
    logic [1:0] hist_q;
    assign sample_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b11;
        end else if (tq_tick) begin
            hist_q <= {hist_q[0], rx_s};
        end
    end
`else
    assign sample_val = rx_s;
`endif

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        ext_n         = ext;
        l2eff_n       = l2eff;
        resync_done_n = resync_done;
        latch_cfg     = 1'b0;
        sample_n      = 1'b0;
        bit_tick_n    = 1'b0;
        sampled_n     = sampled_bit;
        if (tq_tick) begin
            if (hard) begin
                state_n       = ST_TSEG1;
                cnt_n         = 5'd1;
                ext_n         = 3'd0;
                resync_done_n = 1'b0;
                bit_tick_n    = 1'b1;
                latch_cfg     = 1'b1;
            end else begin
                case (state)
                    ST_SYNC: begin
                        state_n   = ST_TSEG1;
                        cnt_n     = 5'd1;
                        latch_cfg = 1'b1;
                    end
                    ST_TSEG1: begin
                        if (cnt == l1) begin
                            state_n   = ST_TSEG2;
                            cnt_n     = 5'd1;
                            sample_n  = 1'b1;
                            sampled_n = sample_val;
                            // A late edge coinciding with the sample point stretches TSEG2 instead.
                            l2eff_n   = resync ? (l2 + min_cs) : l2;
                        end else begin
                            cnt_n = cnt + 5'd1;
                            if (resync) ext_n = min_cs[2:0];
                        end
                        if (resync) resync_done_n = 1'b1;
                    end
                    ST_TSEG2: begin
                        if (resync && (l2 + 5'd1 <= cnt + s_len)) begin
                            state_n       = ST_TSEG1;
                            cnt_n         = 5'd1;
                            ext_n         = 3'd0;
                            resync_done_n = 1'b1;
                            bit_tick_n    = 1'b1;
                            latch_cfg     = 1'b1;
                        end else begin
                            if (resync) begin
                                l2eff_n       = l2_short;
                                resync_done_n = 1'b1;
                            end
                            if (cnt >= (resync ? l2_short : l2eff)) begin
                                state_n       = ST_SYNC;
                                cnt_n         = 5'd0;
                                ext_n         = 3'd0;
                                bit_tick_n    = 1'b1;
                                resync_done_n = 1'b0;
                            end else begin
                                cnt_n = cnt + 5'd1;
                            end
                        end
                    end
                    default: begin
                        state_n = ST_SYNC;
                        cnt_n   = 5'd0;
                        ext_n   = 3'd0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        l1_n  = 5'(tseg1_l) + 5'd1 + 5'(ext_n);
        pos_n = 5'd1;
        case (state_n)
            ST_TSEG1: pos_n = 5'd1 + cnt_n;
            ST_TSEG2: pos_n = 5'd1 + l1_n + cnt_n;
            default:  pos_n = 5'd1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= '1;
            rx_prev      <= 1'b1;
            state        <= ST_SYNC;
            cnt          <= 5'd0;
            ext          <= 3'd0;
            l2eff        <= 5'd1;
            resync_done  <= 1'b0;
            tseg1_l      <= 4'd0;
            tseg2_l      <= 3'd0;
            sjw_l        <= 2'd0;
            sample_point <= 1'b0;
            sampled_bit  <= 1'b1;
            bit_tick     <= 1'b0;
            sync_seg     <= 1'b1;
            in_tseg1     <= 1'b0;
            in_tseg2     <= 1'b0;
            tq_position  <= 5'd1;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], rx};
            if (tq_tick) rx_prev <= rx_s;
            state        <= state_n;
            cnt          <= cnt_n;
            ext          <= ext_n;
            l2eff        <= l2eff_n;
            resync_done  <= resync_done_n;
            if (latch_cfg) begin
                tseg1_l <= tseg1;
                tseg2_l <= tseg2;
                sjw_l   <= sjw;
            end
            sample_point <= sample_n;
            sampled_bit  <= sampled_n;
            bit_tick     <= bit_tick_n;
            sync_seg     <= (state_n == ST_SYNC);
            in_tseg1     <= (state_n == ST_TSEG1);
            in_tseg2     <= (state_n == ST_TSEG2);
            tq_position  <= pos_n;
        end
    end

endmodule
